usb_tx_sequencer: RTL and testbench
===================================

// Module: usb_tx_sequencer
// PURPOSE
//  Transmit-side packet scheduler for the USB encryptor. Arbitrates three packet sources
//  (handshake, token, data) and sequences the granted packet into the byte-serial transmit
//  shifter as SYNC, PID, fields, CRC, then EOP, followed by an inter-packet gap.
//  Generates CRC5 for tokens and CRC16 for data payloads.
// PARAMETERS
//  MAX_DATA_BYTES  8  max payload bytes per data packet; dat_len is clamped to this value
//  GAP_CYCLES      2  idle clk cycles after EOP completes before the next grant; 0 = none
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  hs_req       in   1  handshake request; held until hs_grant
//  hs_pid       in   4  handshake PID, e.g. ACK = 4'b0010
//  hs_grant     out  1  1-cycle pulse; hs_pid sampled this cycle
//  tok_req      in   1  token request; held until tok_grant
//  tok_pid      in   4  token PID
//  tok_addr     in   7  device address
//  tok_endp     in   4  endpoint number
//  tok_grant    out  1  1-cycle pulse; tok_* sampled this cycle
//  dat_req      in   1  data request; held until dat_grant
//  dat_pid      in   4  DATA0/DATA1 PID
//  dat_len      in   4  payload length in bytes, 0..15 (clamped)
//  dat_grant    out  1  1-cycle pulse; dat_pid/dat_len sampled this cycle
//  dat_byte     in   8  current payload byte (show-ahead FIFO head)
//  dat_pop      out  1  1-cycle pulse when dat_byte is accepted by the shifter
//  tx_byte      out  8  byte to the shifter, LSB transmitted first
//  tx_valid     out  1  tx_byte valid
//  tx_ready     in   1  shifter accepts the byte; a transfer occurs when tx_valid & tx_ready
//  tx_eop       out  1  EOP request; held until tx_eop_done
//  tx_eop_done  in   1  1-cycle pulse from the shifter when EOP has been driven
//  busy         out  1  state != IDLE
//  pkt_done     out  1  1-cycle pulse on the GAP->IDLE transition (or EOP->IDLE when GAP_CYCLES=0)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including tx_byte=8'h00. No pop or grant is issued during reset.
//  Reset mid-packet aborts the packet. The shifter is reset alongside this block.
//  Arbitration, IDLE only: fixed priority hs > tok > dat. A grant is a combinational pulse in IDLE.
//  The winner's fields are registered on the grant edge, and the state enters SYNC on the next cycle.
//  Requests raised while busy are not granted. Their sources hold them.
//  States: IDLE, SYNC, PID, TOK1, TOK2, DATA, CRC_LO, CRC_HI, EOP, GAP.
//  Byte states assert tx_valid=1 and hold tx_byte stable until a transfer occurs. A transfer advances the state.
//  The next byte appears in the following cycle.
//   SYNC   tx_byte=8'h80 -> PID
//   PID    tx_byte={~pid,pid}; next: hs->EOP, tok->TOK1, dat->DATA (len>0) or CRC_LO (len=0)
//   TOK1   {endp[0],addr[6:0]} -> TOK2
//   TOK2   {crc5,endp[3:1]}, crc5 = inverted CRC5 over {addr,endp} (11b, poly x5+x2+1, init 5'h1F) -> EOP
//   DATA   tx_byte=dat_byte; dat_pop=1 on transfer; 4b byte counter; last byte -> CRC_LO
//   CRC_LO ~crc16[7:0] -> CRC_HI; CRC_HI ~crc16[15:8] -> EOP
//          (poly 8005h reflected, init FFFFh, cleared at PID, updated per DATA transfer)
//   EOP    tx_valid=0, tx_eop=1 until tx_eop_done -> GAP (or IDLE when GAP_CYCLES=0)
//   GAP    counts GAP_CYCLES cycles -> IDLE
//  Zero-length data packet: CRC bytes are 8'h00, 8'h00. dat_pop never pulses.
//  tx_ready high outside byte states is ignored. tx_eop_done outside EOP is ignored.
//  The gap counter is sized $clog2(GAP_CYCLES+1). The byte counter wraps never, because dat_len is clamped.
// STRUCTURE
//  usb_pkg: state enum, SYNC_BYTE=8'h80, PID constants (OUT/IN/SETUP/DATA0/DATA1/ACK/NAK/STALL),
//  crc5_11b() function.
//  Sub-module usb_crc16_byte: clk, rst, clear, en, din[7:0] -> crc[15:0], single-cycle byte update.
//  The sequencer FSM, arbiter, counters and field registers live in this module.
// TESTING
//  1 ACK: hs_req=1, hs_pid=4'b0010, tx_ready=1 -> hs_grant 1 cycle; bytes 80,D2; tx_eop until done;
//    GAP 2 cycles; pkt_done
//  2 Token SETUP (4'b1101) addr=7'h15 endp=4'hE -> bytes 80,2D,15,BF (crc5=5'h17); then EOP
//  3 DATA0 len=4 with payload 00 01 02 03 -> bytes 80,C3,00..03; 4 dat_pop pulses; CRC bytes match
//    the bench CRC16 model; len=0 -> 80,C3,00,00 and no pop
//  4 hs/tok/dat requests all asserted in the same cycle -> grants in order hs, tok, dat, one packet each;
//    no grant while busy
//  5 tx_ready low for 5 cycles during PID of DATA1 -> tx_byte held at 8'h4B with tx_valid=1; no state advance
//  6 rst=1 during DATA byte 2 -> next cycle IDLE, all outputs 0; a new request is granted normally after reset

Source files
------------

// File: rtl/usb_tx_sequencer_pkg.sv
// Shared types and constants for the USB transmit sequencer: FSM states, PID codes, token CRC5.
package usb_tx_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOK1,
        ST_TOK2,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_HS,
        SRC_TOK,
        SRC_DAT
    } src_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // d[0] is the first bit on the wire (addr LSB); result is the inverted remainder
    function automatic logic [4:0] crc5_11b(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Source request/grant, payload FIFO head and byte-shifter handshake of the transmit sequencer.
interface usb_tx_sequencer_if;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       hs_grant;
    logic       tok_req;
    logic [3:0] tok_pid;
    logic [6:0] tok_addr;
    logic [3:0] tok_endp;
    logic       tok_grant;
    logic       dat_req;
    logic [3:0] dat_pid;
    logic [3:0] dat_len;
    logic       dat_grant;
    logic [7:0] dat_byte;
    logic       dat_pop;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_eop;
    logic       tx_eop_done;
    logic       busy;
    logic       pkt_done;

    modport master (
        output hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
               dat_req, dat_pid, dat_len, dat_byte, tx_ready, tx_eop_done,
        input  hs_grant, tok_grant, dat_grant, dat_pop, tx_byte, tx_valid,
               tx_eop, busy, pkt_done
    );

    modport slave (
        input  hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
               dat_req, dat_pid, dat_len, dat_byte, tx_ready, tx_eop_done,
        output hs_grant, tok_grant, dat_grant, dat_pop, tx_byte, tx_valid,
               tx_eop, busy, pkt_done
    );
endinterface

// File: rtl/usb_tx_sequencer_crc16.sv
// Byte-wide reflected CRC16 (poly 8005h, init FFFFh); result updates one cycle after en.
// No backpressure: clear/en are taken every cycle they are asserted.
module usb_crc16_byte (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);
    logic [15:0] crc_nxt;

    always_comb begin
        crc_nxt = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            if (crc_nxt[0]) crc_nxt = (crc_nxt >> 1) ^ 16'hA001;
            else            crc_nxt = crc_nxt >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) crc <= 16'hFFFF;
        else if (en)      crc <= crc_nxt;
    end
endmodule

// File: rtl/usb_tx_sequencer.sv
// Arbitrates hs > tok > dat in IDLE and emits SYNC/PID/fields/CRC/EOP/gap; grant is combinational, SYNC next cycle.
// Each byte is held on tx_byte with tx_valid until tx_ready; EOP is held until tx_eop_done.
module usb_tx_sequencer
    import usb_tx_sequencer_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int GAP_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_sequencer_if.slave  bus
);
    localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_BYTES);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    src_t             src;
    logic [3:0]       pid, endp, len, byte_cnt;
    logic [6:0]       addr;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      crc16;
    logic [4:0]       crc5;
    logic [3:0]       len_clamped;
    logic             hs_win, tok_win, dat_win;
    logic [7:0]       tx_byte;
    logic             tx_valid, tx_eop, dat_pop, pkt_done;

    assign crc5        = crc5_11b({endp, addr});
    assign len_clamped = (bus.dat_len > MAX_LEN) ? MAX_LEN : bus.dat_len;

    always_comb begin
        hs_win  = 1'b0;
        tok_win = 1'b0;
        dat_win = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (bus.hs_req)       hs_win  = 1'b1;
            else if (bus.tok_req) tok_win = 1'b1;
            else if (bus.dat_req) dat_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_byte   = 8'h00;
        tx_valid  = 1'b0;
        tx_eop    = 1'b0;
        dat_pop   = 1'b0;
        pkt_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_win || tok_win || dat_win) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_byte  = SYNC_BYTE;
                if (bus.tx_ready) state_nxt = ST_PID;
            end
            ST_PID: begin
                tx_valid = 1'b1;
                tx_byte  = {~pid, pid};
                if (bus.tx_ready) begin
                    case (src)
                        SRC_HS:  state_nxt = ST_EOP;
                        SRC_TOK: state_nxt = ST_TOK1;
                        default: state_nxt = (len != 4'd0) ? ST_DATA : ST_CRC_LO;
                    endcase
                end
            end
            ST_TOK1: begin
                tx_valid = 1'b1;
                tx_byte  = {endp[0], addr};
                if (bus.tx_ready) state_nxt = ST_TOK2;
            end
            ST_TOK2: begin
                tx_valid = 1'b1;
                tx_byte  = {crc5, endp[3:1]};
                if (bus.tx_ready) state_nxt = ST_EOP;
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = bus.dat_byte;
                if (bus.tx_ready) begin
                    dat_pop = 1'b1;
                    if (byte_cnt == len - 4'd1) state_nxt = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                tx_valid = 1'b1;
                tx_byte  = ~crc16[7:0];
                if (bus.tx_ready) state_nxt = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                tx_valid = 1'b1;
                tx_byte  = ~crc16[15:8];
                if (bus.tx_ready) state_nxt = ST_EOP;
            end
            ST_EOP: begin
                tx_eop = 1'b1;
                if (bus.tx_eop_done) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                        pkt_done  = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    pkt_done  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Outputs are forced quiet while reset is asserted, even mid-packet
        if (rst) begin
            tx_byte  = 8'h00;
            tx_valid = 1'b0;
            tx_eop   = 1'b0;
            dat_pop  = 1'b0;
            pkt_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src      <= SRC_HS;
            pid      <= 4'h0;
            addr     <= 7'h00;
            endp     <= 4'h0;
            len      <= 4'h0;
            byte_cnt <= 4'h0;
            gap_cnt  <= '0;
        end else begin
            if (hs_win) begin
                src <= SRC_HS;
                pid <= bus.hs_pid;
            end else if (tok_win) begin
                src  <= SRC_TOK;
                pid  <= bus.tok_pid;
                addr <= bus.tok_addr;
                endp <= bus.tok_endp;
            end else if (dat_win) begin
                src <= SRC_DAT;
                pid <= bus.dat_pid;
                len <= len_clamped;
            end
            if (state == ST_PID) byte_cnt <= 4'h0;
            else if (dat_pop)    byte_cnt <= byte_cnt + 4'd1;
            if (state == ST_EOP)      gap_cnt <= '0;
            else if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
        end
    end

    usb_crc16_byte u_crc16 (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_PID),
        .en    (dat_pop),
        .din   (bus.dat_byte),
        .crc   (crc16)
    );

    assign bus.tx_byte   = tx_byte;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_eop    = tx_eop;
    assign bus.dat_pop   = dat_pop;
    assign bus.pkt_done  = pkt_done;
    assign bus.hs_grant  = hs_win;
    assign bus.tok_grant = tok_win;
    assign bus.dat_grant = dat_win;
    assign bus.busy      = !rst && (state != ST_IDLE);
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: packet table plus arbitration and mid-packet reset sequences.
module tb_usb_tx_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_sequencer_if bus();

    usb_tx_sequencer #(.MAX_DATA_BYTES(8), .GAP_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              kind;      // 0 hs, 1 tok, 2 dat
        logic [3:0]      pid;
        logic [6:0]      addr;
        logic [3:0]      endp;
        logic [3:0]      len;
        logic [7:0]      pay0;
        int              nbytes;
        logic [15:0][7:0] exp;
        int              npops;
        int              stall_idx;
        int              stall_len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc16_model(input logic [7:0] p0, input int n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = p0 + 8'(k);
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ b[i];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    function automatic vec_t mk_hs(input logic [3:0] pid, input logic [7:0] pb);
        vec_t v;
        v = '{default: '0};
        v.kind = 0; v.pid = pid; v.nbytes = 2; v.stall_idx = -1;
        v.exp[0] = 8'h80; v.exp[1] = pb;
        return v;
    endfunction

    function automatic vec_t mk_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                                    input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        vec_t v;
        v = '{default: '0};
        v.kind = 1; v.pid = pid; v.addr = addr; v.endp = endp; v.nbytes = 4; v.stall_idx = -1;
        v.exp[0] = 8'h80; v.exp[1] = b1; v.exp[2] = b2; v.exp[3] = b3;
        return v;
    endfunction

    function automatic vec_t mk_dat(input logic [3:0] pid, input logic [7:0] pb, input logic [3:0] len,
                                    input int neff, input logic [7:0] pay0, input int sidx, input int slen);
        vec_t v;
        logic [15:0] c;
        v = '{default: '0};
        v.kind = 2; v.pid = pid; v.len = len; v.pay0 = pay0;
        v.nbytes = neff + 4; v.npops = neff; v.stall_idx = sidx; v.stall_len = slen;
        v.exp[0] = 8'h80; v.exp[1] = pb;
        for (int i = 0; i < neff; i++) v.exp[2 + i] = pay0 + 8'(i);
        c = crc16_model(pay0, neff);
        v.exp[2 + neff] = c[7:0];
        v.exp[3 + neff] = c[15:8];
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        case (v.kind)
            0: begin bus.hs_req = 1'b1; bus.hs_pid = v.pid; end
            1: begin bus.tok_req = 1'b1; bus.tok_pid = v.pid; bus.tok_addr = v.addr; bus.tok_endp = v.endp; end
            default: begin bus.dat_req = 1'b1; bus.dat_pid = v.pid; bus.dat_len = v.len; end
        endcase
    endtask

    task automatic drop_req(input vec_t v);
        case (v.kind)
            0: bus.hs_req = 1'b0;
            1: bus.tok_req = 1'b0;
            default: bus.dat_req = 1'b0;
        endcase
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, bus.tx_valid, 1'b0);
        chk({tag, "_byte"},  bus.tx_byte, 8'h00);
        chk({tag, "_eop"},   bus.tx_eop, 1'b0);
        chk({tag, "_pop"},   bus.dat_pop, 1'b0);
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_done"},  bus.pkt_done, 1'b0);
        chk({tag, "_grant"}, {bus.hs_grant, bus.tok_grant, bus.dat_grant}, 3'b000);
    endtask

    // Requests one packet, acts as the shifter, and checks stream, pops, EOP and gap timing
    task automatic run_pkt(input vec_t v, input string tag);
        int got, pops, eopc, gapc, stall_left, busy_gr, bad_pop;
        logic [7:0] rx [16];
        bit granted, done, eop_pend, eop_sent;
        logic [2:0] gvec;
        got = 0; pops = 0; eopc = 0; gapc = 0; busy_gr = 0; bad_pop = 0;
        granted = 0; done = 0; eop_pend = 0; eop_sent = 0; gvec = 3'b000;
        stall_left = v.stall_len;
        @(posedge clk); #1;
        drive_req(v);
        for (int i = 0; i < 8 && !granted; i++) begin
            @(negedge clk);
            gvec = {bus.hs_grant, bus.tok_grant, bus.dat_grant};
            if (gvec != 3'b000) granted = 1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_grant_seen"}, 32'(granted), 1);
        chk({tag, "_grant_which"}, gvec, 3'b100 >> v.kind);
        @(posedge clk); #1;
        drop_req(v);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            bus.dat_byte    = v.pay0 + 8'(pops);
            bus.tx_ready    = !(got == v.stall_idx && stall_left > 0);
            bus.tx_eop_done = eop_pend;
            if (eop_pend) eop_sent = 1;
            eop_pend = 0;
            @(negedge clk);
            if (bus.hs_grant || bus.tok_grant || bus.dat_grant) busy_gr++;
            if (!bus.tx_ready) begin
                stall_left--;
                chk({tag, "_stall_valid"}, bus.tx_valid, 1'b1);
                chk({tag, "_stall_byte"}, bus.tx_byte, v.exp[got]);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (got < 16) rx[got] = bus.tx_byte;
                got++;
            end
            if (bus.dat_pop) begin
                pops++;
                if (!(bus.tx_valid && bus.tx_ready)) bad_pop++;
            end
            if (bus.tx_eop) begin
                eopc++;
                if (eopc == 3) eop_pend = 1;
            end
            if (eop_sent && !bus.tx_eop && bus.busy) gapc++;
            if (bus.pkt_done) done = 1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_pkt_done"}, 32'(done), 1);
        chk({tag, "_nbytes"}, got, v.nbytes);
        for (int i = 0; i < v.nbytes && i < got; i++)
            chk($sformatf("%s_byte%0d", tag, i), rx[i], v.exp[i]);
        chk({tag, "_pops"}, pops, v.npops);
        chk({tag, "_pop_no_xfer"}, bad_pop, 0);
        chk({tag, "_eop_cycles"}, eopc, 4);
        chk({tag, "_gap_cycles"}, gapc, 2);
        chk({tag, "_grant_busy"}, busy_gr, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int got, pops;
        vecs[0] = mk_hs(4'b0010, 8'hD2);
        vecs[1] = mk_tok(4'b1101, 7'h15, 4'hE, 8'h2D, 8'h15, 8'hBF);
        vecs[2] = mk_dat(4'b0011, 8'hC3, 4'd4, 4, 8'h00, -1, 0);
        vecs[3] = mk_dat(4'b0011, 8'hC3, 4'd0, 0, 8'h00, -1, 0);
        vecs[4] = mk_dat(4'b1011, 8'h4B, 4'd12, 8, 8'h10, 1, 5);
        vecs[5] = mk_hs(4'b1010, 8'h5A);
        vecs[6] = mk_tok(4'b0001, 7'h00, 4'h0, 8'hE1, 8'h00, 8'h40);

        rst = 1'b1;
        bus.hs_req = 0; bus.hs_pid = 0; bus.tok_req = 0; bus.tok_pid = 0; bus.tok_addr = 0; bus.tok_endp = 0;
        bus.dat_req = 0; bus.dat_pid = 0; bus.dat_len = 0; bus.dat_byte = 0;
        bus.tx_ready = 0; bus.tx_eop_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");

        for (int k = 0; k < 7; k++) run_pkt(vecs[k], $sformatf("vec%0d", k));

        // All three sources request together; served hs, tok, dat one packet each
        bus.tok_req = 1'b1; bus.tok_pid = vecs[6].pid; bus.tok_addr = vecs[6].addr; bus.tok_endp = vecs[6].endp;
        bus.dat_req = 1'b1; bus.dat_pid = vecs[3].pid; bus.dat_len = vecs[3].len;
        bus.hs_req  = 1'b1; bus.hs_pid  = vecs[0].pid;
        run_pkt(vecs[0], "arb_hs");
        run_pkt(vecs[6], "arb_tok");
        run_pkt(vecs[3], "arb_dat");

        // Reset while the second payload byte of a DATA0 packet is on the bus
        @(posedge clk); #1;
        bus.dat_req = 1'b1; bus.dat_pid = 4'b0011; bus.dat_len = 4'd4;
        @(negedge clk);
        chk("rst_seq_grant", bus.dat_grant, 1'b1);
        @(posedge clk); #1;
        bus.dat_req = 1'b0; bus.tx_ready = 1'b1;
        got = 0; pops = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            bus.dat_byte = 8'hA0 + 8'(pops);
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) got++;
            if (bus.dat_pop) pops++;
            if (got < 3) begin @(posedge clk); #1; end
        end
        chk("rst_seq_bytes", got, 3);
        chk("rst_seq_pops", pops, 1);
        @(posedge clk); #1;
        bus.dat_byte = 8'hA1;
        @(negedge clk);
        chk("rst_pre_valid", bus.tx_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("in_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        run_pkt(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
